// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and synchronizer limits for the SPI receiver
package spi_pkg;

   // Shallowest synchronizer that still gives metastability settling time
   localparam int SYNC_MIN = 2;

   typedef enum logic [1:0] {
      WAIT_CS = 2'd0,
      IDLE    = 2'd1,
      RECV    = 2'd2
   } spiState_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer with configurable reset value
module sync_bit
   import spi_pkg::*;
#(
   parameter int   STAGES    = SYNC_MIN,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= {STAGES{RESET_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - mode-0 SPI slave receiver with valid/ready output and overrun flag
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SCK,
   input  logic              MOSI,
   input  logic              cs,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_active,
   output logic              frame_err,
   output logic              overrun,
   input  logic              ovr_clr
);

   // Depth is clamped so a too-small parameter cannot defeat the synchronizer
   localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sckS, mosiS, csS;
   logic sckD, csD;
   logic sckRise, csRise;
   logic [SYNC_N-1:0] primeChain;
   logic primed;

   spiState_t state, stateNext;
   logic [CNT_W-1:0]  bitCnt;
   logic [DATA_W-1:0] shiftReg;
   logic [DATA_W-1:0] wordNext;
   logic shiftEn, wordDone, cntClr, errNext;

   // All three pins share one depth so MOSI stays aligned with its SCK edge
   sync_bit #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) uSyncSck (
      .clk(clk), .reset(reset), .d(SCK), .q(sckS));
   sync_bit #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) uSyncMosi (
      .clk(clk), .reset(reset), .d(MOSI), .q(mosiS));
   sync_bit #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) uSyncCs (
      .clk(clk), .reset(reset), .d(cs), .q(csS));

   // Delayed copies for edge detection; primeChain marks when the synchronizers
   // hold real pin samples rather than their reset values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sckD       <= 1'b0;
         csD        <= 1'b1;
         primeChain <= '0;
      end else begin
         sckD       <= sckS;
         csD        <= csS;
         primeChain <= {primeChain[SYNC_N-2:0], 1'b1};
      end
   end

   assign primed   = primeChain[SYNC_N-1];
   assign sckRise  = sckS & ~sckD;
   assign csRise   = csS & ~csD;
   assign wordNext = {shiftReg[DATA_W-2:0], mosiS};

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_CS;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and datapath control; cs release takes priority over a same-cycle SCK edge
   always_comb begin
      stateNext = state;
      shiftEn   = 1'b0;
      wordDone  = 1'b0;
      cntClr    = 1'b0;
      errNext   = 1'b0;
      case (state)
         WAIT_CS: begin
            // Wait for a genuine cs-high sample so a frame cut by reset is skipped
            if (primed && csS) begin
               stateNext = IDLE;
            end
         end
         IDLE: begin
            if (!csS) begin
               stateNext = RECV;
               cntClr    = 1'b1;
            end
         end
         RECV: begin
            if (csRise) begin
               stateNext = IDLE;
               cntClr    = 1'b1;
               errNext   = (bitCnt != '0);
            end else if (sckRise) begin
               shiftEn  = 1'b1;
               wordDone = (bitCnt == LAST_BIT);
            end
         end
         default: stateNext = WAIT_CS;
      endcase
   end

   // Shift register and bit counter; counter wraps so back-to-back words need no cs toggle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitCnt   <= '0;
         shiftReg <= '0;
      end else if (cntClr) begin
         bitCnt <= '0;
      end else if (shiftEn) begin
         shiftReg <= wordNext;
         bitCnt   <= wordDone ? '0 : bitCnt + CNT_W'(1);
      end
   end

   // Output holding register, handshake, frame error pulse and sticky overrun
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= errNext;
         if (wordDone) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= wordNext;
               rx_valid <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (wordDone && rx_valid && !rx_ready) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign frame_active = (state == RECV);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard testbench for spi_slave_rx
module tb_spi_slave_rx;

   logic       clk;
   logic       reset;
   logic       SCK;
   logic       MOSI;
   logic       cs;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_active;
   logic       frame_err;
   logic       overrun;
   logic       ovr_clr;

   logic [7:0] expQ[$];
   int nCompared = 0;
   int nFail     = 0;
   int popCnt    = 0;
   int errCnt    = 0;

   spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .cs(cs),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_active(frame_active), .frame_err(frame_err),
      .overrun(overrun), .ovr_clr(ovr_clr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every accepted word is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (!reset && frame_err) errCnt++;
      if (!reset && rx_valid && rx_ready) begin
         if (expQ.size() == 0) begin
            nCompared++;
            nFail++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", rx_data, $time);
         end else begin
            check("word", {24'd0, rx_data}, {24'd0, expQ.pop_front()});
         end
         popCnt++;
      end
   end

   task automatic sendBit(input logic b, input int ph);
      MOSI = b;
      repeat (ph) @(posedge clk);
      #1 SCK = 1'b1;
      repeat (ph) @(posedge clk);
      #1 SCK = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] v, input int ph);
      for (int i = 7; i >= 0; i--) sendBit(v[i], ph);
   endtask

   task automatic csLow();
      cs = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic csHigh();
      repeat (4) @(posedge clk);
      #1 cs = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_left", expQ.size(), 0);
   endtask

   initial begin
      int p0, e0, ph, len;
      logic [7:0] v;
      logic [7:0] w22;
      SCK = 1'b0; MOSI = 1'b0; cs = 1'b1;
      rx_ready = 1'b0; ovr_clr = 1'b0; reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_active", frame_active, 0);
      check("rst_frame_err", frame_err, 0);
      @(posedge clk) #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Single word 0xA5 with consumer ready
      rx_ready = 1'b1; p0 = popCnt; e0 = errCnt;
      csLow();
      expQ.push_back(8'hA5);
      sendByte(8'hA5, 4);
      @(negedge clk) check("a5_frame_active", frame_active, 1);
      csHigh();
      waitDrain();
      check("a5_word_count", popCnt - p0, 1);
      check("a5_frame_err", errCnt - e0, 0);
      check("a5_overrun", overrun, 0);
      check("a5_idle_inactive", frame_active, 0);

      // Overrun: second word dropped while first is held
      rx_ready = 1'b0;
      csLow();
      expQ.push_back(8'h3C);
      sendByte(8'h3C, 4);
      sendByte(8'hC3, 4);
      @(negedge clk);
      check("ovr_rx_valid", rx_valid, 1);
      check("ovr_rx_data", rx_data, 8'h3C);
      check("ovr_flag", overrun, 1);
      @(posedge clk) #1 ovr_clr = 1'b1;
      @(posedge clk) #1 ovr_clr = 1'b0;
      @(negedge clk) check("ovr_cleared", overrun, 0);
      csHigh();
      rx_ready = 1'b1;
      waitDrain();

      // cs released after 5 bits, then a clean 0x81
      p0 = popCnt; e0 = errCnt;
      csLow();
      for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(1)), 4);
      csHigh();
      check("abort_frame_err", errCnt - e0, 1);
      check("abort_no_word", popCnt - p0, 0);
      csLow();
      expQ.push_back(8'h81);
      sendByte(8'h81, 4);
      csHigh();
      waitDrain();
      check("after_abort_data", rx_data, 8'h81);

      // Reset in the middle of a frame; the remainder must be ignored
      p0 = popCnt;
      csLow();
      for (int i = 0; i < 3; i++) sendBit(1'b1, 4);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_rx_data", rx_data, 0);
      @(posedge clk) #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) sendBit(1'b1, 4);
      @(negedge clk) check("midrst_ignored", frame_active, 0);
      csHigh();
      csLow();
      expQ.push_back(8'h5A);
      sendByte(8'h5A, 4);
      csHigh();
      waitDrain();
      check("midrst_word_count", popCnt - p0, 1);
      check("midrst_data", rx_data, 8'h5A);

      // Handshake lands in the exact cycle the second word completes
      rx_ready = 1'b0;
      w22 = 8'h22;
      csLow();
      expQ.push_back(8'h11);
      expQ.push_back(8'h22);
      sendByte(8'h11, 4);
      for (int i = 7; i >= 1; i--) sendBit(w22[i], 4);
      MOSI = w22[0];
      repeat (4) @(posedge clk);
      #1 SCK = 1'b1;
      @(posedge clk);
      @(posedge clk) #1 rx_ready = 1'b1;
      @(posedge clk) #1 rx_ready = 1'b0;
      @(negedge clk);
      check("same_cycle_valid", rx_valid, 1);
      check("same_cycle_data", rx_data, 8'h22);
      check("same_cycle_overrun", overrun, 0);
      @(posedge clk) #1 SCK = 1'b0;
      csHigh();
      rx_ready = 1'b1;
      waitDrain();

      // Minimum SCK phase, 16 random bytes in one frame
      p0 = popCnt;
      csLow();
      for (int i = 0; i < 16; i++) begin
         v = 8'($urandom);
         expQ.push_back(v);
         sendByte(v, 3);
      end
      csHigh();
      waitDrain();
      check("burst_count", popCnt - p0, 16);
      check("burst_overrun", overrun, 0);

      // Random frames with random phase length
      for (int f = 0; f < 3; f++) begin
         ph  = $urandom_range(6, 3);
         len = $urandom_range(4, 1);
         p0  = popCnt;
         csLow();
         for (int i = 0; i < len; i++) begin
            v = 8'($urandom);
            expQ.push_back(v);
            sendByte(v, ph);
         end
         csHigh();
         waitDrain();
         check("rand_count", popCnt - p0, len);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 8: bits per received word.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer, minimum 2.
REQ-003 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 SCK  in  1  SPI serial clock, asynchronous to clk, idle low (mode 0).
REQ-006 MOSI  in  1  SPI serial data, MSB first, asynchronous to clk.
REQ-007 cs  in  1  SPI chip select, active low, asynchronous to clk.
REQ-008 rx_data  out  DATA_W  last completed word; stable while rx_valid=1.
REQ-009 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  in  1  consumer accepts rx_data in any cycle where rx_valid=1 and rx_ready=1.
REQ-011 frame_active  out  1  high while the FSM is in RECV.
REQ-012 frame_err  out  1  one-cycle pulse when cs deasserts mid-word.
REQ-013 overrun  out  1  sticky flag: a completed word was dropped.
REQ-014 ovr_clr  in  1  clears overrun, synchronous, single cycle.

Function
REQ-015 SCK, MOSI and cs SHALL each pass through a SYNC_STAGES-deep synchronizer of equal depth, so their relative alignment is preserved.
REQ-016 Edges SHALL be detected on the synchronized signals by comparison with a one-cycle-delayed copy.
REQ-017 FSM states: WAIT_CS, IDLE, RECV.
REQ-018 WAIT_CS -> IDLE when synchronized cs=1; no sampling occurs in WAIT_CS.
REQ-019 IDLE -> RECV on synchronized cs=0; bit_cnt cleared to 0 on entry.
REQ-020 In RECV, each synchronized SCK rising edge SHALL shift synchronized MOSI into the LSB of the shift register and increment bit_cnt.
REQ-021 When bit_cnt reaches DATA_W, the word SHALL complete: bit_cnt wraps to 0, and the next word of the same frame starts without re-asserting cs.
REQ-022 A completed word SHALL appear in rx_data with rx_valid=1 on the clock after the edge-detect cycle, i.e. within SYNC_STAGES+2 clk cycles of the pin edge.
REQ-023 rx_valid SHALL clear on the cycle after a handshake, unless a new word completes in that same cycle.
REQ-024 Handshake and word completion in the same cycle: the new word is loaded, rx_valid stays 1, and overrun is not set.
REQ-025 Word completion while rx_valid=1 and rx_ready=0: the new word is dropped, rx_data is unchanged, and overrun is set.
REQ-026 ovr_clr and an overrun event in the same cycle: overrun SHALL be 1 (set wins).
REQ-027 Synchronized cs rising in RECV with bit_cnt!=0: pulse frame_err, discard the partial word, go to IDLE.
REQ-028 Synchronized cs rising in RECV with bit_cnt=0: go to IDLE with no frame_err.
REQ-029 SCK edges SHALL be ignored outside RECV.
REQ-030 Required SCK timing: high and low phases each at least SYNC_STAGES+1 clk periods; behaviour is undefined otherwise.

Reset
REQ-031 On reset: rx_data=0, rx_valid=0, frame_active=0, frame_err=0, overrun=0, bit_cnt=0, shift register=0, synchronizers cleared to SCK=0, MOSI=0, cs=1.
REQ-032 After reset release, the FSM SHALL enter WAIT_CS, so a frame already in progress when reset was applied is ignored until cs is deasserted.

Structure
REQ-033 FSM state encoding and SYNC_STAGES minimum SHALL live in the shared package spi_pkg.
REQ-034 The synchronizer SHALL be one parameterized sub-module, sync_bit, instantiated three times.

Verification
REQ-035 cs low, 8 SCK edges, MOSI 0xA5, rx_ready=1 -> exactly one rx_valid pulse with rx_data=0xA5, no frame_err, no overrun.
REQ-036 One frame carrying 0x3C then 0xC3, rx_ready=0 after the first word -> rx_data=0x3C held, second word dropped, overrun=1; ovr_clr -> overrun=0.
REQ-037 cs raised after 5 bits -> one frame_err pulse, no rx_valid; next frame 0x81 -> rx_data=0x81.
REQ-038 reset pulsed after 3 bits with cs held low, then 5 further bits, then cs high/low and 0x5A -> no word from the interrupted frame; rx_data=0x5A.
REQ-039 rx_ready asserted in the exact cycle the second word of a 0x11, 0x22 frame completes -> rx_valid stays 1, rx_data=0x22, overrun=0.
REQ-040 SCK at the minimum phase of 3 clk periods, random 16-byte frame -> all 16 bytes received in order, no overrun.
